// File: rtl/pi_pkg.sv
// pi_pkg: shared state encoding, widths and saturation helpers for the PI step sequencer
package pi_pkg;
  localparam int Y_W = 9;
  localparam int I_W = 17;
  localparam int G_W = 8;
  typedef enum logic [2:0] {IDLE, REQ, ERR, MUL_I, MUL_P, SUM, SAVE} state_t;
  function automatic logic [Y_W-1:0] sat9(input logic signed [17:0] v);
    return v > 18'sd255 ? 9'h0ff : v < -18'sd256 ? 9'h100 : v[Y_W-1:0];
  endfunction
  function automatic logic [I_W-1:0] sat17(input logic signed [17:0] v);
    return v > 18'sd65535 ? 17'h0ffff : v < -18'sd65536 ? 17'h10000 : v[I_W-1:0];
  endfunction
endpackage

// File: rtl/pi_tick_gen.sv
// pi_tick_gen: sample-period counter emitting one tick every TICK_DIV cycles while enabled
module pi_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  always_comb tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk) cnt <= rst || !enable || tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/pi_step_sequencer.sv
// pi_step_sequencer: one PI-controller update per sample period using a shared two-cycle multiplier
module pi_step_sequencer
  import pi_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int SHIFT    = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [Y_W-1:0] setpoint,
  input  logic [G_W-1:0] kp,
  input  logic [G_W-1:0] ki,
  output logic           adc_req,
  input  logic           adc_valid,
  input  logic [Y_W-1:0] adc_data,
  input  logic [I_W-1:0] ik1,
  output logic [Y_W-1:0] yk,
  output logic [I_W-1:0] ik,
  output logic           save,
  output logic           busy,
  output logic           overrun
);
  state_t state, nxt;
  logic tick;
  logic [Y_W-1:0] fb, e;
  logic [G_W-1:0] kp_r, ki_r, mul_a;
  logic [I_W-1:0] prod, p, ikn;
  logic signed [17:0] diff, isum, u;
  pi_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .tick(tick)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = tick ? REQ : IDLE;
      REQ:     nxt = !enable ? IDLE : adc_valid ? ERR : REQ;
      ERR:     nxt = MUL_I;
      MUL_I:   nxt = MUL_P;
      MUL_P:   nxt = SUM;
      SUM:     nxt = SAVE;
      default: nxt = IDLE;
    endcase
    adc_req = state == REQ;
    save    = state == SAVE;
    busy    = state != IDLE;
  end
  always_comb mul_a = state == MUL_I ? ki_r : state == MUL_P ? kp_r : '0;
  assign prod = {{9{mul_a[G_W-1]}}, mul_a} * {{8{e[Y_W-1]}}, e};
  assign diff = {{9{setpoint[Y_W-1]}}, setpoint} - {{9{fb[Y_W-1]}}, fb};
  assign isum = {ik1[I_W-1], ik1} + {prod[I_W-1], prod};
  assign u    = {p[I_W-1], p} + {ikn[I_W-1], ikn};
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      fb      <= '0;
      e       <= '0;
      kp_r    <= '0;
      ki_r    <= '0;
      p       <= '0;
      ikn     <= '0;
      yk      <= '0;
      ik      <= '0;
      overrun <= 1'b0;
    end else begin
      if (state == REQ && nxt == ERR) fb <= adc_data;
      if (state == ERR) begin
        e    <= sat9(diff);
        kp_r <= kp;
        ki_r <= ki;
      end
      if (state == MUL_I) ikn <= sat17(isum);
      if (state == MUL_P) p <= prod;
      if (state == SUM) begin
        yk <= sat9(u >>> SHIFT);
        ik <= ikn;
      end
      overrun <= overrun | (tick & busy);
    end
  end
endmodule
